// File: rtl/imem_rsp_if.sv
// imem_rsp_if -- fetch request/response bus between a fetch unit and imem_rsp.
//   req_valid/req_addr/req_ready : fetch request handshake (PC in req_addr)
//   flush                        : redirect, abandons any in-flight fetch
//   rsp_valid/rsp_ready          : response handshake
//   rsp_instr/rsp_pc/rsp_err     : fetched word, its address, AdEL flag
// Modports: master = fetch unit side, slave = instruction memory side.
interface imem_rsp_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_pc;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, flush, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_err
    );
endinterface

// File: rtl/imem_rsp.sv
// imem_rsp -- instruction memory with fixed-latency fetch response.
//   CLK      : clock, rising edge
//   Reset_n  : asynchronous active-low reset (memory contents are kept)
//   fetch    : imem_rsp_if.slave fetch request/response bus
//   ld_we    : program-load write enable
//   ld_idx   : program-load word index
//   ld_data  : program-load data word
// A request accepted at edge k is answered from edge k+LAT onwards; the
// answer is held until consumed or dropped by flush/reset. Misaligned or
// out-of-range addresses answer with rsp_err=1 and a zero word.
module imem_rsp #(
    parameter int unsigned LAT   = 2,
    parameter logic [31:0] BASE  = 32'h0000_3000,
    parameter int unsigned WORDS = 4096
) (
    input  logic          CLK,
    input  logic          Reset_n,
    imem_rsp_if.slave     fetch,
    input  logic          ld_we,
    input  logic [11:0]   ld_idx,
    input  logic [31:0]   ld_data
);

    localparam logic [31:0] LAST = BASE + 32'(4 * WORDS) - 32'd4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [31:0] r_addr;
    logic [31:0] r_rsp_instr;
    logic [31:0] r_rsp_pc;
    logic        r_rsp_err;
    logic [31:0] r_mem [WORDS];

    logic        w_accept;
    logic        w_enter_resp;
    logic [31:0] w_fetch_addr;
    logic        w_adel;
    logic [11:0] w_idx;

    // With LAT=0 the response is captured on the acceptance edge itself,
    // before r_addr holds the address, so take it straight off the bus.
    assign w_fetch_addr = (r_state == IDLE) ? fetch.req_addr : r_addr;
    assign w_adel = (w_fetch_addr[1:0] != 2'b00) || (w_fetch_addr < BASE) ||
                    (w_fetch_addr > LAST);
    assign w_idx  = 12'((w_fetch_addr - BASE) >> 2);

    assign fetch.req_ready = (r_state == IDLE) && !fetch.flush;
    assign fetch.rsp_valid = (r_state == RESP);
    assign fetch.rsp_instr = r_rsp_instr;
    assign fetch.rsp_pc    = r_rsp_pc;
    assign fetch.rsp_err   = r_rsp_err;

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        if (fetch.flush) begin
            w_next_state = IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (fetch.req_valid) begin
                        w_accept = 1'b1;
                        if (LAT == 0) begin
                            w_next_state = RESP;
                            w_enter_resp = 1'b1;
                        end else begin
                            w_next_state = WAIT;
                            w_cnt_next   = 4'(LAT - 1);
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        w_next_state = RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (fetch.rsp_ready) begin
                        w_next_state = IDLE;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_rsp_instr <= '0;
            r_rsp_pc    <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_addr <= fetch.req_addr;
            end
            // Read uses the pre-edge memory image, so a load on this same
            // edge is not seen by this response.
            if (w_enter_resp) begin
                r_rsp_pc    <= w_fetch_addr;
                r_rsp_err   <= w_adel;
                r_rsp_instr <= w_adel ? '0 : r_mem[w_idx];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (ld_we) begin
            r_mem[ld_idx] <= ld_data;
        end
    end

endmodule

// File: tb/tb_imem_rsp.sv
// tb_imem_rsp -- directed self-checking bench for imem_rsp.
// u_dut2 runs with LAT=2, u_dut0 with LAT=0; both share clock, reset and
// the program-load port so they hold identical memory images.
module tb_imem_rsp;

    logic        clk;
    logic        rst_n;
    logic        ld_we;
    logic [11:0] ld_idx;
    logic [31:0] ld_data;
    int          checks;
    int          errors;

    imem_rsp_if if2 ();
    imem_rsp_if if0 ();

    imem_rsp #(.LAT(2), .BASE(32'h0000_3000), .WORDS(4096)) u_dut2 (
        .CLK(clk), .Reset_n(rst_n), .fetch(if2.slave),
        .ld_we(ld_we), .ld_idx(ld_idx), .ld_data(ld_data)
    );

    imem_rsp #(.LAT(0), .BASE(32'h0000_3000), .WORDS(4096)) u_dut0 (
        .CLK(clk), .Reset_n(rst_n), .fetch(if0.slave),
        .ld_we(ld_we), .ld_idx(ld_idx), .ld_data(ld_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [11:0] idx, input logic [31:0] data);
        ld_we = 1'b1; ld_idx = idx; ld_data = data;
        tick();
        ld_we = 1'b0;
    endtask

    // Presents one request to the LAT=2 DUT for exactly one edge.
    task automatic issue2(input logic [31:0] addr);
        if2.req_valid = 1'b1; if2.req_addr = addr;
        tick();
        if2.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if2.req_valid = 1'b0; if2.req_addr = '0; if2.flush = 1'b0; if2.rsp_ready = 1'b1;
        if0.req_valid = 1'b0; if0.req_addr = '0; if0.flush = 1'b0; if0.rsp_ready = 1'b1;
        ld_we = 1'b0; ld_idx = '0; ld_data = '0;
        repeat (2) tick();
        checks++;
        if (if2.rsp_valid !== 1'b0 || if2.rsp_instr !== 32'h0 || if2.rsp_pc !== 32'h0 || if2.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b instr=%h pc=%h err=%b, want 0/0/0/0",
                     if2.rsp_valid, if2.rsp_instr, if2.rsp_pc, if2.rsp_err);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (if2.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready: got %b want 1", if2.req_ready);
        end
        load(12'd0, 32'h3c01_0001);
        load(12'd5, 32'h1111_2222);
        load(12'd6, 32'haaaa_0006);
        load(12'd4095, 32'hdead_beef);
    endtask

    task automatic test_basic();
        if2.rsp_ready = 1'b1;
        issue2(32'h0000_3000);
        checks++;
        if (if2.rsp_valid !== 1'b0 || if2.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_cycle1: valid=%b ready=%b want 0/0", if2.rsp_valid, if2.req_ready);
        end
        tick();
        checks++;
        if (if2.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_cycle2: valid=%b want 0", if2.rsp_valid);
        end
        tick();
        checks++;
        if (if2.rsp_valid !== 1'b1 || if2.rsp_instr !== 32'h3c01_0001 || if2.rsp_pc !== 32'h3000 || if2.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_resp: valid=%b instr=%h pc=%h err=%b want 1/3c010001/00003000/0",
                     if2.rsp_valid, if2.rsp_instr, if2.rsp_pc, if2.rsp_err);
        end
        tick();
        checks++;
        if (if2.rsp_valid !== 1'b0 || if2.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_exit: valid=%b ready=%b want 0/1", if2.rsp_valid, if2.req_ready);
        end
    endtask

    task automatic test_adel();
        logic [31:0] addrs [4];
        logic [31:0] instrs [4];
        logic        errs [4];
        addrs  = '{32'h3002, 32'h2ffc, 32'h7000, 32'h6ffc};
        instrs = '{32'h0, 32'h0, 32'h0, 32'hdead_beef};
        errs   = '{1'b1, 1'b1, 1'b1, 1'b0};
        if2.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue2(addrs[i]);
            tick();
            checks++;
            if (if2.rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL adel_latency[%0d]: valid=%b want 0 one cycle early", i, if2.rsp_valid);
            end
            tick();
            checks++;
            if (if2.rsp_valid !== 1'b1 || if2.rsp_err !== errs[i] || if2.rsp_instr !== instrs[i] || if2.rsp_pc !== addrs[i]) begin
                errors++;
                $display("FAIL adel_resp[%0d]: valid=%b err=%b instr=%h pc=%h want 1/%b/%h/%h",
                         i, if2.rsp_valid, if2.rsp_err, if2.rsp_instr, if2.rsp_pc, errs[i], instrs[i], addrs[i]);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        if2.rsp_ready = 1'b0;
        issue2(32'h0000_3014);
        repeat (2) tick();
        checks++;
        if (if2.rsp_valid !== 1'b1 || if2.rsp_instr !== 32'h1111_2222 || if2.rsp_pc !== 32'h3014) begin
            errors++;
            $display("FAIL stall_resp: valid=%b instr=%h pc=%h want 1/11112222/00003014",
                     if2.rsp_valid, if2.rsp_instr, if2.rsp_pc);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (if2.rsp_valid !== 1'b1 || if2.rsp_instr !== 32'h1111_2222 || if2.rsp_pc !== 32'h3014 ||
                if2.rsp_err !== 1'b0 || if2.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b instr=%h pc=%h err=%b ready=%b want 1/11112222/00003014/0/0",
                         i, if2.rsp_valid, if2.rsp_instr, if2.rsp_pc, if2.rsp_err, if2.req_ready);
            end
        end
        if2.rsp_ready = 1'b1;
        tick();
        checks++;
        if (if2.rsp_valid !== 1'b0 || if2.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: valid=%b ready=%b want 0/1", if2.rsp_valid, if2.req_ready);
        end
    endtask

    task automatic test_load_race();
        if2.rsp_ready = 1'b1;
        // load strictly before the RESP-entry edge: new data
        issue2(32'h0000_3018);
        ld_we = 1'b1; ld_idx = 12'd6; ld_data = 32'hbbbb_0006;
        tick();
        ld_we = 1'b0;
        tick();
        checks++;
        if (if2.rsp_valid !== 1'b1 || if2.rsp_instr !== 32'hbbbb_0006) begin
            errors++;
            $display("FAIL load_before: valid=%b instr=%h want 1/bbbb0006", if2.rsp_valid, if2.rsp_instr);
        end
        tick();
        // load on the RESP-entry edge: old data
        issue2(32'h0000_3018);
        tick();
        ld_we = 1'b1; ld_idx = 12'd6; ld_data = 32'hcccc_0006;
        tick();
        ld_we = 1'b0;
        checks++;
        if (if2.rsp_valid !== 1'b1 || if2.rsp_instr !== 32'hbbbb_0006) begin
            errors++;
            $display("FAIL load_concurrent: valid=%b instr=%h want 1/bbbb0006", if2.rsp_valid, if2.rsp_instr);
        end
        tick();
        issue2(32'h0000_3018);
        repeat (2) tick();
        checks++;
        if (if2.rsp_valid !== 1'b1 || if2.rsp_instr !== 32'hcccc_0006) begin
            errors++;
            $display("FAIL load_after: valid=%b instr=%h want 1/cccc0006", if2.rsp_valid, if2.rsp_instr);
        end
        tick();
    endtask

    task automatic test_flush();
        logic seen;
        if2.rsp_ready = 1'b1;
        // flush during WAIT
        issue2(32'h0000_3000);
        if2.flush = 1'b1;
        #1;
        checks++;
        if (if2.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready_low: got %b want 0", if2.req_ready);
        end
        tick();
        if2.flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen |= if2.rsp_valid;
            tick();
        end
        checks++;
        if (seen !== 1'b0 || if2.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_wait: stale_valid=%b ready=%b want 0/1", seen, if2.req_ready);
        end
        // flush while presenting, together with rsp_ready
        if2.rsp_ready = 1'b0;
        issue2(32'h0000_3000);
        repeat (2) tick();
        checks++;
        if (if2.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_resp_pre: valid=%b want 1", if2.rsp_valid);
        end
        if2.flush = 1'b1; if2.rsp_ready = 1'b1;
        tick();
        if2.flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen |= if2.rsp_valid;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_resp: stale_valid=%b want 0", seen);
        end
        // flush with req_valid in IDLE
        if2.flush = 1'b1; if2.req_valid = 1'b1; if2.req_addr = 32'h3000;
        #1;
        checks++;
        if (if2.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_ready: got %b want 0", if2.req_ready);
        end
        tick();
        if2.flush = 1'b0; if2.req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen |= if2.rsp_valid;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: stale_valid=%b want 0", seen);
        end
        // next request served normally
        issue2(32'h0000_3014);
        repeat (2) tick();
        checks++;
        if (if2.rsp_valid !== 1'b1 || if2.rsp_instr !== 32'h1111_2222 || if2.rsp_pc !== 32'h3014) begin
            errors++;
            $display("FAIL flush_recover: valid=%b instr=%h pc=%h want 1/11112222/00003014",
                     if2.rsp_valid, if2.rsp_instr, if2.rsp_pc);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic seen;
        if2.rsp_ready = 1'b1;
        issue2(32'h0000_3000);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (if2.rsp_valid !== 1'b0 || if2.req_ready !== 1'b1 || if2.rsp_instr !== 32'h0 || if2.rsp_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b ready=%b instr=%h pc=%h want 0/1/0/0",
                     if2.rsp_valid, if2.req_ready, if2.rsp_instr, if2.rsp_pc);
        end
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen |= if2.rsp_valid;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_stale: stale_valid=%b want 0", seen);
        end
        // memory survives reset
        issue2(32'h0000_3000);
        repeat (2) tick();
        checks++;
        if (if2.rsp_valid !== 1'b1 || if2.rsp_instr !== 32'h3c01_0001) begin
            errors++;
            $display("FAIL reset_mem_kept: valid=%b instr=%h want 1/3c010001", if2.rsp_valid, if2.rsp_instr);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] instrs [3];
        addrs  = '{32'h3000, 32'h3014, 32'h6ffc};
        instrs = '{32'h3c01_0001, 32'h1111_2222, 32'hdead_beef};
        if0.rsp_ready = 1'b1;
        if0.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if0.req_addr = addrs[i];
            tick();
            checks++;
            if (if0.rsp_valid !== 1'b1 || if0.rsp_pc !== addrs[i] || if0.rsp_instr !== instrs[i] || if0.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL lat0_resp[%0d]: valid=%b pc=%h instr=%h ready=%b want 1/%h/%h/0",
                         i, if0.rsp_valid, if0.rsp_pc, if0.rsp_instr, if0.req_ready, addrs[i], instrs[i]);
            end
            tick();
            checks++;
            if (if0.rsp_valid !== 1'b0 || if0.req_ready !== 1'b1) begin
                errors++;
                $display("FAIL lat0_gap[%0d]: valid=%b ready=%b want 0/1", i, if0.rsp_valid, if0.req_ready);
            end
        end
        if0.req_valid = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_adel();
        test_stall();
        test_load_race();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
